// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: dual-write-port register file with optional bypass, registered read and busy scoreboard
//   i_CLK, i_Reset       : rising-edge clock, asynchronous active-low reset
//   i_A1/i_A2            : read addresses -> o_RD1/o_RD2 data, o_Busy1/o_Busy2 pending-write flags
//   i_WE3/i_A3/i_WD3     : write port A (execute writeback)
//   i_WE4/i_A4/i_WD4     : write port B (memory writeback), wins over port A on the same address
//   i_SetBusy/i_BusyAddr : mark a destination register as awaiting a result
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input  logic              i_CLK,
    input  logic              i_Reset,
    input  logic [ADDR_W-1:0] i_A1,
    input  logic [ADDR_W-1:0] i_A2,
    output logic [DATA_W-1:0] o_RD1,
    output logic [DATA_W-1:0] o_RD2,
    input  logic              i_WE3,
    input  logic [ADDR_W-1:0] i_A3,
    input  logic [DATA_W-1:0] i_WD3,
    input  logic              i_WE4,
    input  logic [ADDR_W-1:0] i_A4,
    input  logic [DATA_W-1:0] i_WD4,
    input  logic              i_SetBusy,
    input  logic [ADDR_W-1:0] i_BusyAddr,
    output logic              o_Busy1,
    output logic              o_Busy2
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic we3, we4, set;
    logic [1:0][ADDR_W-1:0] ra;
    logic [1:0][DATA_W-1:0] rd;
    logic [1:0] bz;

    // Qualify every state change so register 0 is never written nor marked busy.
    assign we3 = i_WE3 && !(ZERO_REG != 0 && i_A3 == '0);
    assign we4 = i_WE4 && !(ZERO_REG != 0 && i_A4 == '0);
    assign set = i_SetBusy && !(ZERO_REG != 0 && i_BusyAddr == '0);
    assign ra = {i_A2, i_A1};

    // Order gives port B priority over A, and a new producer's set over any clear.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (we3) begin
            mem_d[i_A3]  = i_WD3;
            busy_d[i_A3] = 1'b0;
        end
        if (we4) begin
            mem_d[i_A4]  = i_WD4;
            busy_d[i_A4] = 1'b0;
        end
        if (set) busy_d[i_BusyAddr] = 1'b1;
    end

    always_ff @(posedge i_CLK or negedge i_Reset) begin
        if (!i_Reset) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        if (READ_REG != 0) begin : g_reg
            logic [DATA_W-1:0] rd_q;
            logic              bz_q;
            // Capturing next-state arrays gives the post-edge view, forwarding included.
            always_ff @(posedge i_CLK or negedge i_Reset) begin
                if (!i_Reset) begin
                    rd_q <= '0;
                    bz_q <= 1'b0;
                end else begin
                    rd_q <= mem_d[ra[p]];
                    bz_q <= busy_d[ra[p]];
                end
            end
            assign rd[p] = rd_q;
            assign bz[p] = bz_q;
        end else begin : g_comb
            logic h3, h4;
            assign h4 = BYPASS != 0 && we4 && i_A4 == ra[p];
            assign h3 = BYPASS != 0 && we3 && i_A3 == ra[p];
            assign rd[p] = h4 ? i_WD4 : h3 ? i_WD3 : mem_q[ra[p]];
            // A forwarded result is no longer pending.
            assign bz[p] = busy_q[ra[p]] && !h3 && !h4;
        end
    end

    // Forwarding would otherwise leak write data onto the outputs while in reset.
    assign o_RD1   = i_Reset ? rd[0] : '0;
    assign o_RD2   = i_Reset ? rd[1] : '0;
    assign o_Busy1 = i_Reset && bz[0];
    assign o_Busy2 = i_Reset && bz[1];
endmodule
